// File: rtl/calculation_mul_arbiter.sv
// Shares one 16x16 multiplier among NREQ requesters; product ids ride a tag pipe into a tagged FIFO.
// Build option: define MUL_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module calculation_mul_arbiter #(
  parameter int NREQ       = 4,
  parameter int MUL_LAT    = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int IDW        = 2
) (
  input  logic                 mulit_clk,
  input  logic                 mulit_rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [16*NREQ-1:0]   req_a,
  input  logic [16*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic [15:0]          mul_a,
  output logic [15:0]          mul_b,
  input  logic [31:0]          mul_out,
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic [31:0]          rsp_data,
  input  logic                 rsp_ready,
  output logic                 busy
);
  localparam int PW     = $clog2(FIFO_DEPTH);
  localparam int CW     = PW + 1;
  localparam int TW     = IDW + 1;
  localparam int PIPE_W = TW * (MUL_LAT + 1);

  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     fifo_count;
  logic              credit;
  logic              grant_any;
  logic              xfer;
  logic              push;
  logic              pop;
  logic [IDW-1:0]    grant_id;
  logic [15:0]       sel_a;
  logic [15:0]       sel_b;
  logic [PIPE_W-1:0] tag_pipe;
  logic [TW-1:0]     tag_in;
  logic [TW-1:0]     tag_out;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [31:0]       mem_data [FIFO_DEPTH];
  logic [IDW-1:0]    mem_id   [FIFO_DEPTH];

  // Credit counts every issued product until it is popped, so a full FIFO can never be pushed.
  assign credit = !mulit_rst && (outstanding < CW'(FIFO_DEPTH));

`ifdef MUL_ARB_FIXED_PRIO_EN
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!grant_any && req_valid[IDW'(i)]) begin
        grant_any = 1'b1;
        grant_id  = IDW'(i);
      end
    end
  end
`else
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] rr_idx;

  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    rr_idx    = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      rr_idx = IDW'((32'(rr_ptr) + k) % NREQ);
      if (!grant_any && req_valid[rr_idx]) begin
        grant_any = 1'b1;
        grant_id  = rr_idx;
      end
    end
  end

  always_ff @(posedge mulit_clk or posedge mulit_rst) begin
    if (mulit_rst)
      rr_ptr <= IDW'(NREQ - 1);
    else if (xfer)
      rr_ptr <= grant_id;
  end
`endif

  assign xfer      = credit && grant_any;
  assign req_ready = xfer ? (NREQ'(1) << grant_id) : '0;

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_id == IDW'(i)) begin
        sel_a = req_a[16*i +: 16];
        sel_b = req_b[16*i +: 16];
      end
    end
  end

  always_ff @(posedge mulit_clk or posedge mulit_rst) begin
    if (mulit_rst) begin
      mul_a <= '0;
      mul_b <= '0;
    end else if (xfer) begin
      mul_a <= sel_a;
      mul_b <= sel_b;
    end
  end

  // Stage 0 sits in the low bits; the oldest stage lines up with a valid mul_out.
  assign tag_in  = {xfer, grant_id};
  assign tag_out = tag_pipe[PIPE_W-1 -: TW];
  assign push    = tag_out[TW-1];

  if (MUL_LAT == 0) begin : g_tag_lat0
    always_ff @(posedge mulit_clk or posedge mulit_rst) begin
      if (mulit_rst)
        tag_pipe <= '0;
      else
        tag_pipe <= tag_in;
    end
  end else begin : g_tag_latn
    always_ff @(posedge mulit_clk or posedge mulit_rst) begin
      if (mulit_rst)
        tag_pipe <= '0;
      else
        tag_pipe <= {tag_pipe[PIPE_W-TW-1:0], tag_in};
    end
  end

  assign pop = rsp_valid && rsp_ready;

  always_ff @(posedge mulit_clk or posedge mulit_rst) begin
    if (mulit_rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      outstanding <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_data[PW'(i)] <= '0;
        mem_id[PW'(i)]   <= '0;
      end
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= mul_out;
        mem_id[wr_ptr]   <= tag_out[IDW-1:0];
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
      case ({xfer, pop})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  assign rsp_valid = (fifo_count != '0);
  assign rsp_id    = mem_id[rd_ptr];
  assign rsp_data  = mem_data[rd_ptr];
  assign busy      = (outstanding != '0);

endmodule

// File: tb/tb_calculation_mul_arbiter.sv
// Directed bench for calculation_mul_arbiter with a one-cycle registered multiplier model.
module tb_calculation_mul_arbiter;
  localparam int NREQ       = 4;
  localparam int MUL_LAT    = 1;
  localparam int FIFO_DEPTH = 4;
  localparam int IDW        = 2;

  logic                 mulit_clk = 1'b0;
  logic                 mulit_rst;
  logic [NREQ-1:0]      req_valid;
  logic [16*NREQ-1:0]   req_a;
  logic [16*NREQ-1:0]   req_b;
  logic [NREQ-1:0]      req_ready;
  logic [15:0]          mul_a;
  logic [15:0]          mul_b;
  logic [31:0]          mul_out = '0;
  logic                 rsp_valid;
  logic [IDW-1:0]       rsp_id;
  logic [31:0]          rsp_data;
  logic                 rsp_ready;
  logic                 busy;

  int tests = 0;
  int fails = 0;
  int ri;

  logic [3:0]  ct_grant [3];
  logic [1:0]  ct_id    [3];
  logic [31:0] ct_data  [3];
  logic [3:0]  bp_grant [4];
  logic [3:0]  bp_resume;
  logic [1:0]  bp_id    [5];
  logic [31:0] bp_data  [5];

  calculation_mul_arbiter #(
    .NREQ(NREQ), .MUL_LAT(MUL_LAT), .FIFO_DEPTH(FIFO_DEPTH), .IDW(IDW)
  ) dut (
    .mulit_clk(mulit_clk), .mulit_rst(mulit_rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .mul_a(mul_a), .mul_b(mul_b), .mul_out(mul_out),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_ready(rsp_ready), .busy(busy)
  );

  always #5 mulit_clk = ~mulit_clk;

  always @(posedge mulit_clk) mul_out <= mul_a * mul_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 0);
    chk({tag, "_mul_a"},     32'(mul_a),     0);
    chk({tag, "_mul_b"},     32'(mul_b),     0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    chk({tag, "_rsp_id"},    32'(rsp_id),    0);
    chk({tag, "_rsp_data"},  rsp_data,       0);
    chk({tag, "_busy"},      32'(busy),      0);
  endtask

  initial begin
`ifdef MUL_ARB_FIXED_PRIO_EN
    ct_grant = '{4'b0001, 4'b0001, 4'b0001};
    ct_id    = '{2'd0, 2'd0, 2'd0};
    ct_data  = '{32'd69732, 32'd69732, 32'd69732};
    bp_grant = '{4'b0001, 4'b0001, 4'b0001, 4'b0001};
    bp_resume = 4'b0001;
    bp_id    = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    bp_data  = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
`else
    ct_grant = '{4'b0001, 4'b0010, 4'b0100};
    ct_id    = '{2'd0, 2'd1, 2'd2};
    ct_data  = '{32'd69732, 32'd7800, 32'd7140};
    bp_grant = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    bp_resume = 4'b0010;
    bp_id    = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    bp_data  = '{32'd7800, 32'd7140, 32'hFFFE0001, 32'd0, 32'd7800};
`endif

    mulit_rst = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    #3;
    chk_reset_outputs("reset");
    @(negedge mulit_clk);
    @(negedge mulit_clk);
    mulit_rst = 1'b0;
    @(negedge mulit_clk);

    // Contention: three requesters held valid, consumer always ready.
    set_op(0, 16'd447, 16'd156);
    set_op(1, 16'd120, 16'd65);
    set_op(2, 16'd510, 16'd14);
    req_valid = 4'b0111;
    ri = 0;
    for (int c = 0; c < 14; c++) begin
      if (c == 6) req_valid = '0;
      #1;
      if (c < 6) chk("ct_grant", 32'(req_ready), 32'(ct_grant[c % 3]));
      if (rsp_valid) begin
        if (ri < 6) begin
          chk("ct_id",   32'(rsp_id), 32'(ct_id[ri % 3]));
          chk("ct_data", rsp_data,    ct_data[ri % 3]);
        end
        ri++;
      end
      @(negedge mulit_clk);
    end
    chk("ct_count", ri, 6);
    chk("ct_idle",  32'(busy), 0);

    // Single request latency: 510*14.
    set_op(0, 16'd510, 16'd14);
    req_valid = 4'b0001;
    #1;
    chk("single_grant", 32'(req_ready), 32'b0001);
    @(negedge mulit_clk);
    req_valid = '0;
    #1;
    chk("single_mul_a", 32'(mul_a), 510);
    chk("single_mul_b", 32'(mul_b), 14);
    chk("single_busy",  32'(busy), 1);
    chk("single_rsp_e1", 32'(rsp_valid), 0);
    @(negedge mulit_clk);
    chk("single_rsp_e2", 32'(rsp_valid), 0);
    @(negedge mulit_clk);
    chk("single_rsp_valid", 32'(rsp_valid), 1);
    chk("single_rsp_id",    32'(rsp_id), 0);
    chk("single_rsp_data",  rsp_data, 7140);
    @(negedge mulit_clk);
    chk("single_drained", 32'(rsp_valid), 0);
    chk("single_not_busy", 32'(busy), 0);

    // Backpressure: consumer stalled, all four requesters valid.
    set_op(0, 16'd0, 16'd1234);
    set_op(1, 16'd120, 16'd65);
    set_op(2, 16'd510, 16'd14);
    set_op(3, 16'hFFFF, 16'hFFFF);
    rsp_ready = 1'b0;
    req_valid = 4'b1111;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("bp_grant", 32'(req_ready), (c < 4) ? 32'(bp_grant[c]) : 32'd0);
      @(negedge mulit_clk);
    end
    chk("bp_busy",  32'(busy), 1);
    chk("bp_full",  32'(rsp_valid), 1);
    rsp_ready = 1'b1;
    #1;
    chk("bp_no_credit_on_pop", 32'(req_ready), 0);
    ri = 0;
    for (int c = 0; c < 10; c++) begin
      if (c == 2) req_valid = '0;
      #1;
      if (c == 1) chk("bp_resume", 32'(req_ready), 32'(bp_resume));
      if (rsp_valid) begin
        if (ri < 5) begin
          chk("bp_id",   32'(rsp_id), 32'(bp_id[ri]));
          chk("bp_data", rsp_data,    bp_data[ri]);
        end
        ri++;
      end
      @(negedge mulit_clk);
    end
    chk("bp_count", ri, 5);
    chk("bp_idle",  32'(busy), 0);

    // Reset with three products outstanding and requesters still valid.
    rsp_ready = 1'b0;
    req_valid = 4'b0111;
    repeat (3) @(negedge mulit_clk);
    chk("rst_busy_before", 32'(busy), 1);
    mulit_rst = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    req_valid = '0;
    @(negedge mulit_clk);
    @(negedge mulit_clk);
    mulit_rst = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 4'b0010;
    #1;
    chk("post_rst_grant", 32'(req_ready), 32'b0010);
    @(negedge mulit_clk);
    req_valid = '0;
    ri = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (rsp_valid) begin
        if (ri == 0) begin
          chk("post_rst_id",   32'(rsp_id), 1);
          chk("post_rst_data", rsp_data, 7800);
        end
        ri++;
      end
      @(negedge mulit_clk);
    end
    chk("post_rst_count", ri, 1);
    chk("post_rst_idle",  32'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/calculation_mul_arbiter.md
# calculation_mul_arbiter

Round-robin arbiter and sequencer that shares the single 16x16 unsigned multiplier (`Calculation_mulit`) among `NREQ` requesters in the Kmeans datapath, e.g. distance units needing squared differences. It accepts operand pairs over valid/ready handshakes, issues one pair per cycle to the multiplier, and tracks each product's requester id through the multiplier latency. Products are returned through a tagged response FIFO with backpressure.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `MUL_LAT`, 1: cycles from operands at `mul_a`/`mul_b` to a valid `mul_out`, 0..4.
- `FIFO_DEPTH`, 4: response FIFO entries, power of two, ≥ `MUL_LAT`+2.
- `IDW`, 2: id width, = clog2(`NREQ`).

Ports:
- `mulit_clk`  in  1  clock, all state on rising edge.
- `mulit_rst`  in  1  asynchronous reset, active-high.
- `req_valid`  in  NREQ  per-requester operand valid.
- `req_a`  in  16*NREQ  operand A, requester i at [16i+15:16i].
- `req_b`  in  16*NREQ  operand B, same packing.
- `req_ready`  out  NREQ  one-hot grant; transfer when `req_valid[i]` & `req_ready[i]`.
- `mul_a`  out  16  registered operand A to multiplier.
- `mul_b`  out  16  registered operand B to multiplier.
- `mul_out`  in  32  multiplier product.
- `rsp_valid`  out  1  response FIFO non-empty.
- `rsp_id`  out  IDW  requester index of head product.
- `rsp_data`  out  32  head product.
- `rsp_ready`  in  1  consumer pop; pop when `rsp_valid` & `rsp_ready`.
- `busy`  out  1  any product in flight or in FIFO.

## Operation
- Credit: `outstanding` = in-flight tag count + FIFO count. Issue is allowed only when `outstanding` < `FIFO_DEPTH`. A pop in the same cycle does not create issue credit.
- Grant is combinational from `req_valid`, the rr pointer and the credit. At most one `req_ready` bit is high. If there is no credit, `req_ready` = 0.
- Round-robin search starts at pointer+1 modulo `NREQ`. The pointer loads the granted index only on an accepted transfer. Reset value is `NREQ`-1, so requester 0 has first priority.
- On transfer, `mul_a`/`mul_b` load the granted operands, and tag pipe stage 0 loads {1, id}. With no transfer, `mul_a`/`mul_b` hold their value and stage 0 valid clears.
- The tag pipe has `MUL_LAT`+1 stages. When the last stage is valid, {id, `mul_out`} is written to the FIFO.
- The FIFO supports simultaneous push and pop, and then its count is unchanged. A push when full cannot occur, because credit prevents it.
- Products are unsigned 32-bit and are passed through unmodified.
- `busy` = (`outstanding` ≠ 0).

## Timing
- Reset values: `req_ready`=0, `mul_a`=0, `mul_b`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `busy`=0. The tag pipe, FIFO pointers and counts are cleared.
- Reset mid-operation discards all in-flight and queued products.
- Latency: with a transfer at edge E and an empty FIFO, `rsp_valid` rises after edge E+`MUL_LAT`+1, and `rsp_data` equals the product of that pair.
- Throughput: one transfer per cycle when `rsp_ready`=1 and `FIFO_DEPTH` ≥ `MUL_LAT`+2.
- Ordering: responses leave in issue order, including across requesters.
- Backpressure: with `rsp_ready`=0, exactly `FIFO_DEPTH` transfers are accepted, then `req_ready`=0. Issue resumes one cycle after the first pop.
- A requester may drop `req_valid` without a transfer. The pointer is unaffected.

## Configuration
- `MUL_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority, lowest index wins. The rr pointer is removed.
  - Undefined (default): round-robin as above.
  - Credit, tag pipe and FIFO behaviour are identical in both modes.

## Test plan
- Single request, `MUL_LAT`=1: req0 a=510, b=14 → `rsp_valid` two cycles after the handshake, `rsp_id`=0, `rsp_data`=7140, then `busy`=0.
- Contention: req0 {447,156}, req1 {120,65} and req2 {510,14} held continuously with `rsp_ready`=1 → grants in order 0,1,2,0,1,2…. Responses carry ids 0,1,2 with data 69732, 7800, 7140, and there are no idle issue cycles.
- Backpressure: `rsp_ready`=0 with all requesters valid → exactly 4 transfers, then `req_ready`=0. Raising `rsp_ready` pops in issue order and restores grants.
- Boundary: a=65535, b=65535 → `rsp_data`=0xFFFE0001. A zero operand gives 0.
- Reset mid-operation: assert `mulit_rst` with 3 products outstanding → all outputs take their reset values immediately. After release, req1 {120,65} returns 7800 with id 1 and no stale responses.
- `MUL_ARB_FIXED_PRIO_EN` defined, req0 and req2 continuously valid → req2 is never granted while req0 stays valid.
